uart_rx_control_path: RTL and testbench

- UART receiver: the far end of the team's UART TX frame format.
- Frame: start bit, 8 data bits LSB first, then either 1 parity bit or an 8-bit CRC byte (LSB first), then 1 stop bit.
- Oversamples the serial line with a 16x baud strobe and recovers data, parity or CRC, and line errors.
- Delivers each frame to the packet/CRC-check logic as a one-cycle valid pulse.

---
 rtl/uart_rx_control_path.sv | 273 +++++++++++++++++++++++++++
 tb/tb_uart_rx_control_path.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_control_path.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx_control_path
// Description : UART receiver for the team's TX frame format.
//               Frame = start, 8 data bits LSB first, then either one parity
//               bit or an 8-bit CRC byte (LSB first), then one stop bit.
//               The line is oversampled with an OS_RATE x baud strobe. Each
//               completed frame is presented with a one-clock valid pulse
//               together with data, CRC and error flags.
// Ports       :
//   clk_i        in   system clock
//   rst_i        in   asynchronous active-high reset
//   rx_i         in   serial line (asynchronous, idles high)
//   os_tick_i    in   one-clock strobe at OS_RATE x baud
//   crc_en_i     in   1 = frame carries a CRC byte instead of parity
//   rx_data_o    out  last received data byte
//   rx_crc_o     out  last received CRC byte (held across parity frames)
//   rx_valid_o   out  one-clock pulse when a frame completes
//   parity_err_o out  parity mismatch in last frame (0 for CRC frames)
//   frame_err_o  out  stop bit sampled low in last frame
//   busy_o       out  receiver is inside a frame
// Parameters  :
//   OS_RATE      oversampling ticks per bit; power of 2, minimum 8
//   PARITY_ODD   0 = even parity expected, 1 = odd parity expected
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_control_path #(
    parameter int OS_RATE    = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    input  logic       os_tick_i,
    input  logic       crc_en_i,
    output logic [7:0] rx_data_o,
    output logic [7:0] rx_crc_o,
    output logic       rx_valid_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int                c_OS_W    = $clog2(OS_RATE);
    // Mid-bit point of the start bit; from here every later sample lands one
    // full bit period later, i.e. at the middle of each following bit.
    localparam logic [c_OS_W-1:0] c_OS_HALF = c_OS_W'(OS_RATE / 2 - 1);
    localparam logic [c_OS_W-1:0] c_OS_LAST = c_OS_W'(OS_RATE - 1);

    typedef enum logic [2:0] {
        RX_IDLE       = 3'd0,
        RX_START_BIT  = 3'd1,
        RX_DATA_BITS  = 3'd2,
        RX_PARITY_BIT = 3'd3,
        RX_CRC        = 3'd4,
        RX_STOP_BIT   = 3'd5
    } t_rx_state;

    // ------------------------------------------------------------------
    // Input synchronizer (resets to the idle line level)
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic w_rxs;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs = r_sync2;

    // ------------------------------------------------------------------
    // FSM and counters
    // ------------------------------------------------------------------
    t_rx_state         r_state;
    t_rx_state         w_state_nxt;
    logic [c_OS_W-1:0] r_os_cnt;
    logic [c_OS_W-1:0] w_os_cnt_nxt;
    logic [2:0]        r_bit_cnt;
    logic [2:0]        w_bit_cnt_nxt;
    logic              r_crc_en;

    // One-clock strobes telling the datapath what to capture this cycle
    logic              w_latch_crc_en;
    logic              w_smp_data;
    logic              w_smp_par;
    logic              w_smp_crc;
    logic              w_smp_stop;
    logic              w_os_last;

    assign w_os_last = (r_os_cnt == c_OS_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= RX_IDLE;
            r_os_cnt  <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_os_cnt  <= w_os_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_os_cnt_nxt   = r_os_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_latch_crc_en = 1'b0;
        w_smp_data     = 1'b0;
        w_smp_par      = 1'b0;
        w_smp_crc      = 1'b0;
        w_smp_stop     = 1'b0;

        // Nothing moves between oversample strobes
        if (os_tick_i) begin
            case (r_state)
                RX_IDLE: begin
                    if (!w_rxs) begin
                        w_state_nxt  = RX_START_BIT;
                        w_os_cnt_nxt = '0;
                    end
                end

                RX_START_BIT: begin
                    if (r_os_cnt == c_OS_HALF) begin
                        w_os_cnt_nxt = '0;
                        if (w_rxs) begin
                            // Line went back high before mid-start: glitch
                            w_state_nxt = RX_IDLE;
                        end else begin
                            w_latch_crc_en = 1'b1;
                            w_bit_cnt_nxt  = '0;
                            w_state_nxt    = RX_DATA_BITS;
                        end
                    end else begin
                        w_os_cnt_nxt = r_os_cnt + 1'b1;
                    end
                end

                RX_DATA_BITS: begin
                    if (w_os_last) begin
                        w_smp_data    = 1'b1;
                        w_os_cnt_nxt  = '0;
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;  // wraps 7 -> 0
                        if (r_bit_cnt == 3'd7) begin
                            w_state_nxt = r_crc_en ? RX_CRC : RX_PARITY_BIT;
                        end
                    end else begin
                        w_os_cnt_nxt = r_os_cnt + 1'b1;
                    end
                end

                RX_PARITY_BIT: begin
                    if (w_os_last) begin
                        w_smp_par    = 1'b1;
                        w_os_cnt_nxt = '0;
                        w_state_nxt  = RX_STOP_BIT;
                    end else begin
                        w_os_cnt_nxt = r_os_cnt + 1'b1;
                    end
                end

                RX_CRC: begin
                    if (w_os_last) begin
                        w_smp_crc     = 1'b1;
                        w_os_cnt_nxt  = '0;
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) begin
                            w_state_nxt = RX_STOP_BIT;
                        end
                    end else begin
                        w_os_cnt_nxt = r_os_cnt + 1'b1;
                    end
                end

                RX_STOP_BIT: begin
                    // Leaving at mid-stop leaves half a bit to catch the
                    // start edge of a back-to-back frame.
                    if (w_os_last) begin
                        w_smp_stop   = 1'b1;
                        w_os_cnt_nxt = '0;
                        w_state_nxt  = RX_IDLE;
                    end else begin
                        w_os_cnt_nxt = r_os_cnt + 1'b1;
                    end
                end

                default: begin
                    w_state_nxt  = RX_IDLE;
                    w_os_cnt_nxt = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath: shift registers and per-frame flags
    // ------------------------------------------------------------------
    logic [7:0] r_data_sh;
    logic [7:0] r_crc_sh;
    logic       r_par_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_crc_en  <= 1'b0;
            r_data_sh <= '0;
            r_crc_sh  <= '0;
            r_par_err <= 1'b0;
        end else begin
            // crc_en_i only matters at start-bit confirmation
            if (w_latch_crc_en) begin
                r_crc_en <= crc_en_i;
            end
            if (w_smp_data) begin
                r_data_sh[r_bit_cnt] <= w_rxs;
            end
            if (w_smp_par) begin
                r_par_err <= ((^r_data_sh) ^ w_rxs) != PARITY_ODD;
            end
            if (w_smp_crc) begin
                r_crc_sh[r_bit_cnt] <= w_rxs;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers: loaded on the stop sample, so they change (and the
    // valid pulse appears) in the clock following it, then hold.
    // ------------------------------------------------------------------
    logic [7:0] r_rx_data;
    logic [7:0] r_rx_crc;
    logic       r_rx_valid;
    logic       r_parity_err;
    logic       r_frame_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rx_data    <= '0;
            r_rx_crc     <= '0;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_valid <= w_smp_stop;
            if (w_smp_stop) begin
                r_rx_data    <= r_data_sh;
                // A stale parity result must not leak into a CRC frame
                r_parity_err <= r_crc_en ? 1'b0 : r_par_err;
                r_frame_err  <= ~w_rxs;
                if (r_crc_en) begin
                    r_rx_crc <= r_crc_sh;
                end
            end
        end
    end

    assign rx_data_o    = r_rx_data;
    assign rx_crc_o     = r_rx_crc;
    assign rx_valid_o   = r_rx_valid;
    assign parity_err_o = r_parity_err;
    assign frame_err_o  = r_frame_err;
    assign busy_o       = (r_state != RX_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_control_path.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_control_path
// Description : Directed self-checking bench for uart_rx_control_path.
//               os_tick is every 2nd clock, so one bit = 16 ticks = 32 clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_control_path;

    localparam int BIT_CLKS = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       os_tick;
    logic       crc_en;
    logic [7:0] rx_data;
    logic [7:0] rx_crc;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    logic       tdiv = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) tdiv <= ~tdiv;
    assign os_tick = tdiv;

    uart_rx_control_path #(
        .OS_RATE    (16),
        .PARITY_ODD (1'b0)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rx_i         (rx),
        .os_tick_i    (os_tick),
        .crc_en_i     (crc_en),
        .rx_data_o    (rx_data),
        .rx_crc_o     (rx_crc),
        .rx_valid_o   (rx_valid),
        .parity_err_o (parity_err),
        .frame_err_o  (frame_err),
        .busy_o       (busy)
    );

    // Pulse monitor: sampled on the falling edge, away from the active edge
    int         pulse_cnt = 0;
    int         busy_clks = 0;
    logic [7:0] hist_data [32];
    logic [7:0] last_data = '0;
    logic [7:0] last_crc  = '0;
    logic       last_perr = 1'b0;
    logic       last_ferr = 1'b0;

    always @(negedge clk) begin
        if (rx_valid) begin
            hist_data[pulse_cnt % 32] = rx_data;
            last_data = rx_data;
            last_crc  = rx_crc;
            last_perr = parity_err;
            last_ferr = frame_err;
            pulse_cnt++;
        end
        if (busy) busy_clks++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic idle_clks(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // ext: parity in bit 0 or the whole CRC byte; flip toggles crc_en mid-data
    task automatic send_frame(input logic [7:0] d, input logic crc, input logic [7:0] ext,
                              input logic stop, input logic flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (flip && i == 3) crc_en = ~crc_en;
            send_bit(d[i]);
        end
        if (crc) begin
            for (int i = 0; i < 8; i++) send_bit(ext[i]);
        end else begin
            send_bit(ext[0]);
        end
        send_bit(stop);
    endtask

    int p0;
    int b0;
    int db;

    initial begin
        rst    = 1'b1;
        rx     = 1'b1;
        crc_en = 1'b0;
        repeat (4) @(negedge clk);

        // Reset state
        check("rst_data",  32'(rx_data),    32'h00);
        check("rst_crc",   32'(rx_crc),     32'h00);
        check("rst_valid", 32'(rx_valid),   32'h0);
        check("rst_perr",  32'(parity_err), 32'h0);
        check("rst_ferr",  32'(frame_err),  32'h0);
        check("rst_busy",  32'(busy),       32'h0);
        rst = 1'b0;
        idle_clks(10);
        check("idle_busy", 32'(busy), 32'h0);

        // 1: even parity, 0xA5 (four ones -> parity 0)
        p0 = pulse_cnt;
        send_frame(8'hA5, 1'b0, 8'h00, 1'b1, 1'b0);
        idle_clks(2 * BIT_CLKS);
        check("t1_pulses", 32'(pulse_cnt - p0), 32'd1);
        check("t1_data",   32'(last_data), 32'hA5);
        check("t1_perr",   32'(last_perr), 32'h0);
        check("t1_ferr",   32'(last_ferr), 32'h0);
        check("t1_crc",    32'(last_crc),  32'h00);

        // 2: CRC frame; crc_en flips mid-frame and must be ignored.
        // Busy spans half start + 8 data + 8 CRC + 1 stop = 17.5 bit times.
        crc_en = 1'b1;
        p0 = pulse_cnt;
        b0 = busy_clks;
        send_frame(8'h3C, 1'b1, 8'hD2, 1'b1, 1'b1);
        idle_clks(2 * BIT_CLKS);
        db = busy_clks - b0;
        check("t2_pulses", 32'(pulse_cnt - p0), 32'd1);
        check("t2_data",   32'(last_data), 32'h3C);
        check("t2_crc",    32'(last_crc),  32'hD2);
        check("t2_perr",   32'(last_perr), 32'h0);
        check("t2_ferr",   32'(last_ferr), 32'h0);
        check("t2_busy_window", 32'(db >= 17 * BIT_CLKS && db <= 18 * BIT_CLKS), 32'h1);
        check("t2_crc_en_now_low", 32'(crc_en), 32'h0);

        // 3: parity error, then correct parity; CRC output held
        p0 = pulse_cnt;
        send_frame(8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        idle_clks(BIT_CLKS);
        check("t3a_pulses", 32'(pulse_cnt - p0), 32'd1);
        check("t3a_data",   32'(last_data), 32'h01);
        check("t3a_perr",   32'(last_perr), 32'h1);
        check("t3a_crc_held", 32'(last_crc), 32'hD2);
        p0 = pulse_cnt;
        send_frame(8'h01, 1'b0, 8'h01, 1'b1, 1'b0);
        idle_clks(BIT_CLKS);
        check("t3b_pulses", 32'(pulse_cnt - p0), 32'd1);
        check("t3b_perr",   32'(last_perr), 32'h0);

        // 4: stop bit low, then line held low (break)
        p0 = pulse_cnt;
        send_frame(8'h55, 1'b0, 8'h00, 1'b0, 1'b0);
        check("t4_pulses", 32'(pulse_cnt - p0), 32'd1);
        check("t4_data",   32'(last_data), 32'h55);
        check("t4_ferr",   32'(last_ferr), 32'h1);
        check("t4_perr",   32'(last_perr), 32'h0);
        // Break frames repeat every 10.5 bits (336 clks): two in 800 clks
        p0 = pulse_cnt;
        rx = 1'b0;
        repeat (800) @(negedge clk);
        check("t4_brk_pulses", 32'(pulse_cnt - p0), 32'd2);
        check("t4_brk_data",   32'(last_data), 32'h00);
        check("t4_brk_ferr",   32'(last_ferr), 32'h1);
        idle_clks(500);
        check("t4_recover_busy", 32'(busy), 32'h0);

        // 5: 4-tick low glitch on an idle line
        p0 = pulse_cnt;
        rx = 1'b0;
        repeat (6) @(negedge clk);
        check("t5_busy_rise", 32'(busy), 32'h1);
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (24) @(negedge clk);
        check("t5_busy_fall", 32'(busy), 32'h0);
        idle_clks(100);
        check("t5_no_pulse", 32'(pulse_cnt - p0), 32'd0);

        // 6: reset mid-data-bit, then a clean 0x7E (six ones -> parity 0)
        p0 = pulse_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        rx = 1'b0;
        repeat (BIT_CLKS / 2) @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_rst_busy", 32'(busy),      32'h0);
        check("t6_rst_data", 32'(rx_data),   32'h00);
        check("t6_rst_crc",  32'(rx_crc),    32'h00);
        check("t6_rst_ferr", 32'(frame_err), 32'h0);
        rst = 1'b0;
        idle_clks(2 * BIT_CLKS);
        check("t6_no_pulse", 32'(pulse_cnt - p0), 32'd0);
        p0 = pulse_cnt;
        send_frame(8'h7E, 1'b0, 8'h00, 1'b1, 1'b0);
        idle_clks(BIT_CLKS);
        check("t6_pulses", 32'(pulse_cnt - p0), 32'd1);
        check("t6_data",   32'(last_data), 32'h7E);
        check("t6_perr",   32'(last_perr), 32'h0);
        check("t6_ferr",   32'(last_ferr), 32'h0);
        check("t6_crc",    32'(last_crc),  32'h00);

        // Back-to-back 0x11 / 0x22 with no idle gap
        p0 = pulse_cnt;
        send_frame(8'h11, 1'b0, 8'h00, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 8'h00, 1'b1, 1'b0);
        idle_clks(2 * BIT_CLKS);
        check("b2b_pulses", 32'(pulse_cnt - p0), 32'd2);
        check("b2b_first",  32'(hist_data[p0 % 32]), 32'h11);
        check("b2b_second", 32'(hist_data[(p0 + 1) % 32]), 32'h22);
        check("b2b_perr",   32'(last_perr), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
